// File: rtl/multi_core_nonce_ctrl_if.sv
// rtl/multi_core_nonce_ctrl_if.sv - work, hit and transmit signals of the nonce controller
interface multi_core_nonce_ctrl_if #(
  parameter int CORES = 2
);
  logic             work_load;
  logic [31:0]      start_nonce;
  logic [CORES-1:0] hit;
  logic             tx_busy;
  logic [5:0]       cnt;
  logic             feedback;
  logic [31:0]      nonce_base;
  logic             tx_send;
  logic [31:0]      tx_word;
  logic [15:0]      hit_count;
  logic [7:0]       drop_count;

  modport master (
    output work_load, start_nonce, hit, tx_busy,
    input  cnt, feedback, nonce_base, tx_send, tx_word, hit_count, drop_count
  );

  modport slave (
    input  work_load, start_nonce, hit, tx_busy,
    output cnt, feedback, nonce_base, tx_send, tx_word, hit_count, drop_count
  );
endinterface

// File: rtl/multi_core_nonce_ctrl.sv
// rtl/multi_core_nonce_ctrl.sv - multi-core round sequencer, hit qualifier and golden-nonce transmitter
module multi_core_nonce_ctrl #(
  parameter int CORES      = 2,
  parameter int LOOP_LOG2  = 5,
  parameter int FIFO_DEPTH = 4
) (
  input logic                     hash_clk,
  input logic                     reset_n,
  multi_core_nonce_ctrl_if.slave  bus
);
  localparam int LOOP = 1 << LOOP_LOG2;
  localparam int RESULT_OFFSET = (LOOP_LOG2 == 0) ? 131 :
                                 (LOOP_LOG2 == 1) ? 66 : (1 << (7 - LOOP_LOG2)) + 1;
  localparam logic [31:0] RESULT_SPAN = 32'(RESULT_OFFSET * CORES);
  localparam logic [5:0]  CNT_MASK    = 6'(LOOP - 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = (CORES > 1) ? $clog2(CORES) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_e;

  logic [5:0]       cnt_q, cnt_d;
  logic             feedback_q, feedback_d;
  logic             feedback_d1_q, feedback_d1_d;
  logic [31:0]      nonce_base_q, nonce_base_d;
  logic [7:0]       flush_q, flush_d;
  logic [CORES-1:0] pending_q, pending_d;
  logic [31:0]      result_base_q, result_base_d;
  logic [15:0]      hit_count_q, hit_count_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [31:0]      mem_d [FIFO_DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  tx_state_e        state_q, state_d;
  logic [1:0]       wait_q, wait_d;
  logic             tx_send_q, tx_send_d;
  logic [31:0]      tx_word_q, tx_word_d;

  logic             fifo_empty, fifo_full, pop, push, drain_valid;
  logic [IW-1:0]    drain_idx;
  logic [CORES-1:0] pending_next;
  logic [7:0]       drops;
  logic [8:0]       drop_sum;

  // Next-state for sequencer, result qualification, drain, FIFO and transmit handshake
  always_comb begin
    // Sequencer: issue whenever the next round counter returns to zero
    cnt_d = (cnt_q + 6'd1) & CNT_MASK;
    if (bus.work_load) cnt_d = '0;
    feedback_d    = (cnt_d != 6'd0);
    feedback_d1_d = feedback_q;
    nonce_base_d  = nonce_base_q;
    if (bus.work_load)    nonce_base_d = bus.start_nonce;
    else if (!feedback_d) nonce_base_d = nonce_base_q + 32'(CORES);

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    pop        = (state_q == TX_IDLE) && !fifo_empty && !bus.tx_busy;

    // Drain the lowest pending core; a pop this cycle frees a slot for it
    drain_valid = 1'b0;
    drain_idx   = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        drain_valid = 1'b1;
        drain_idx   = IW'(i);
      end
    end
    push         = drain_valid && (!fifo_full || pop);
    pending_next = pending_q;
    if (push) pending_next[drain_idx] = 1'b0;

    // A new sample owns the pending vector; leftovers of the old group are lost
    pending_d     = pending_next;
    flush_d       = flush_q;
    result_base_d = result_base_q;
    drops         = '0;
    if (!feedback_d1_q) begin
      for (int i = 0; i < CORES; i++) drops = drops + 8'(pending_next[i]);
      if (flush_q != 8'd0) begin
        flush_d   = flush_q - 8'd1;
        pending_d = '0;
      end else begin
        result_base_d = nonce_base_q - RESULT_SPAN;
        pending_d     = bus.hit;
      end
    end
    if (bus.work_load) begin
      pending_d = '0;
      flush_d   = 8'(RESULT_OFFSET);
      drops     = '0;
    end

    drop_sum     = {1'b0, drop_count_q} + {1'b0, drops};
    drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    hit_count_d  = (push && hit_count_q != 16'hFFFF) ? hit_count_q + 16'd1 : hit_count_q;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = result_base_q + 32'(drain_idx);
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // Transmit handshake: send, wait for busy to rise (or time out), wait for it to fall
    state_d   = state_q;
    wait_d    = wait_q;
    tx_send_d = 1'b0;
    tx_word_d = tx_word_q;
    case (state_q)
      TX_IDLE: begin
        if (pop) begin
          tx_word_d = mem_q[rd_ptr_q[PW-1:0]];
          tx_send_d = 1'b1;
          wait_d    = '0;
          state_d   = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: begin
        if (bus.tx_busy)          state_d = TX_WAIT_DONE;
        else if (wait_q == 2'd3)  state_d = TX_IDLE;
        else                      wait_d  = wait_q + 2'd1;
      end
      TX_WAIT_DONE: begin
        if (!bus.tx_busy) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      feedback_q    <= 1'b0;
      feedback_d1_q <= 1'b0;
      nonce_base_q  <= '0;
      flush_q       <= 8'(RESULT_OFFSET);
      pending_q     <= '0;
      result_base_q <= '0;
      hit_count_q   <= '0;
      drop_count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      state_q       <= TX_IDLE;
      wait_q        <= '0;
      tx_send_q     <= 1'b0;
      tx_word_q     <= '0;
    end else begin
      cnt_q         <= cnt_d;
      feedback_q    <= feedback_d;
      feedback_d1_q <= feedback_d1_d;
      nonce_base_q  <= nonce_base_d;
      flush_q       <= flush_d;
      pending_q     <= pending_d;
      result_base_q <= result_base_d;
      hit_count_q   <= hit_count_d;
      drop_count_q  <= drop_count_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      state_q       <= state_d;
      wait_q        <= wait_d;
      tx_send_q     <= tx_send_d;
      tx_word_q     <= tx_word_d;
    end
  end

  assign bus.cnt        = cnt_q;
  assign bus.feedback   = feedback_q;
  assign bus.nonce_base = nonce_base_q;
  assign bus.tx_send    = tx_send_q;
  assign bus.tx_word    = tx_word_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_multi_core_nonce_ctrl.sv
// tb/tb_multi_core_nonce_ctrl.sv - randomized bench for multi_core_nonce_ctrl with a behavioural model
module tb_multi_core_nonce_ctrl;
  localparam int CORES      = 2;
  localparam int LOOP_LOG2  = 5;
  localparam int LOOP       = 1 << LOOP_LOG2;
  localparam int RO         = (1 << (7 - LOOP_LOG2)) + 1;
  localparam int FIFO_DEPTH = 4;

  logic hash_clk = 1'b0;
  logic reset_n  = 1'b0;

  multi_core_nonce_ctrl_if #(.CORES(CORES)) bus_if ();

  multi_core_nonce_ctrl #(.CORES(CORES), .LOOP_LOG2(LOOP_LOG2), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .hash_clk (hash_clk),
    .reset_n  (reset_n),
    .bus      (bus_if)
  );

  always #5 hash_clk = ~hash_clk;

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  logic [31:0] cur_start = '0;
  logic [31:0] exp_q[$];
  logic [31:0] sent_q[$];
  int          exp_hits = 0;
  int          exp_drops = 0;
  int          busy_mode = 1;
  int          busy_min = 1;
  int          busy_max = 4;

  // serial_transmit stand-in: records every send and answers with a busy pulse
  initial begin : responder
    int          left;
    logic [31:0] held;
    left = 0;
    held = '0;
    bus_if.tx_busy = 1'b0;
    forever begin
      @(negedge hash_clk);
      if (!reset_n) begin
        left = 0;
        bus_if.tx_busy = 1'b0;
      end else begin
        if (bus_if.tx_send === 1'b1) begin
          checks++;
          if (bus_if.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL send_while_busy: tx_busy=%b at tx_send, required 0", bus_if.tx_busy);
          end
          sent_q.push_back(bus_if.tx_word);
          held = bus_if.tx_word;
          if (busy_mode == 1) left = $urandom_range(busy_max, busy_min);
        end else if (busy_mode == 1 && bus_if.tx_busy === 1'b1) begin
          checks++;
          if (bus_if.tx_word !== held) begin
            errors++;
            $display("FAIL tx_word_stable: got %h while busy, required %h", bus_if.tx_word, held);
          end
        end
        if (busy_mode == 2) bus_if.tx_busy = 1'b1;
        else if (left > 0) begin
          bus_if.tx_busy = 1'b1;
          left--;
        end else bus_if.tx_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge hash_clk);
    k++;
  endtask

  task automatic clear_model();
    exp_q.delete();
    sent_q.delete();
    exp_hits  = 0;
    exp_drops = 0;
  endtask

  task automatic load(input logic [31:0] s);
    while (k % LOOP == 0) tick();
    bus_if.work_load   = 1'b1;
    bus_if.start_nonce = s;
    @(negedge hash_clk);
    bus_if.work_load = 1'b0;
    k = 0;
    cur_start = s;
  endtask

  // Drive one sample; results of sample index s belong to group start + CORES*(s - RO)
  task automatic sample(input logic [CORES-1:0] h);
    int          s;
    logic [31:0] b;
    tick();
    while (k % LOOP != 1) tick();
    s = k / LOOP;
    bus_if.hit = h;
    if (s >= RO) begin
      b = cur_start + 32'(CORES * (s - RO));
      for (int i = 0; i < CORES; i++) begin
        if (h[i]) begin
          exp_q.push_back(b + 32'(i));
          exp_hits++;
        end
      end
    end
    tick();
    bus_if.hit = '0;
  endtask

  task automatic wait_sends(input string name);
    int guard;
    guard = 0;
    while (sent_q.size() < exp_q.size() && guard < 3000) begin
      tick();
      guard++;
    end
    repeat (16) tick();
    checks++;
    if (sent_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_send_count: got %0d sends, required %0d", name, sent_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (sent_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_word%0d: got %h, required %h", name, i, sent_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (bus_if.hit_count !== 16'(exp_hits)) begin
      errors++;
      $display("FAIL %s_hit_count: got %0d, required %0d", name, bus_if.hit_count, exp_hits);
    end
    checks++;
    if (bus_if.drop_count !== 8'(exp_drops)) begin
      errors++;
      $display("FAIL %s_drop_count: got %0d, required %0d", name, bus_if.drop_count, exp_drops);
    end
    exp_q.delete();
    sent_q.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({bus_if.cnt, bus_if.feedback, bus_if.nonce_base, bus_if.tx_send, bus_if.tx_word,
         bus_if.hit_count, bus_if.drop_count} !== '0) begin
      errors++;
      $display("FAIL %s: got cnt=%0d fb=%b nb=%h send=%b word=%h hits=%0d drops=%0d, required all 0",
               name, bus_if.cnt, bus_if.feedback, bus_if.nonce_base, bus_if.tx_send,
               bus_if.tx_word, bus_if.hit_count, bus_if.drop_count);
    end
  endtask

  task automatic test_reset();
    bus_if.work_load   = 1'b0;
    bus_if.start_nonce = '0;
    bus_if.hit         = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge hash_clk);
    check_zero_outputs("reset_state");
    reset_n = 1'b1;
    k = 0;
    clear_model();
  endtask

  task automatic test_sequencer();
    logic [31:0] e_nb;
    load(32'h1000);
    for (int n = 0; n < 70; n++) begin
      e_nb = cur_start + 32'(CORES * (k / LOOP));
      checks++;
      if (bus_if.cnt !== 6'(k % LOOP) || bus_if.feedback !== (k % LOOP != 0) || bus_if.nonce_base !== e_nb) begin
        errors++;
        $display("FAIL sequencer_k%0d: got cnt=%0d fb=%b nb=%h, required cnt=%0d fb=%b nb=%h",
                 k, bus_if.cnt, bus_if.feedback, bus_if.nonce_base, k % LOOP, (k % LOOP != 0), e_nb);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    load(32'h1000);
    for (int n = 0; n < RO; n++) sample(CORES'($urandom_range(3, 1)));
    wait_sends("flush");
  endtask

  task automatic test_golden();
    sample(2'b10);
    wait_sends("golden");
  endtask

  task automatic test_simultaneous();
    sample(2'b11);
    wait_sends("simultaneous");
  endtask

  task automatic test_random();
    busy_mode = 1;
    busy_min  = 1;
    busy_max  = 4;
    load($urandom());
    for (int n = 0; n < RO; n++) sample(CORES'($urandom_range(3, 0)));
    for (int n = 0; n < 20; n++) sample(CORES'($urandom_range(3, 0)));
    wait_sends("random");
  endtask

  task automatic test_timeout();
    busy_mode = 0;
    sample(2'b11);
    wait_sends("timeout");
    busy_mode = 1;
  endtask

  task automatic test_backpressure();
    busy_mode = 2;
    repeat (3) sample(2'b11);
    sample(2'b00);
    while (exp_q.size() > FIFO_DEPTH) begin
      void'(exp_q.pop_back());
      exp_hits--;
      exp_drops++;
    end
    repeat (10) tick();
    checks++;
    if (sent_q.size() != 0) begin
      errors++;
      $display("FAIL backpressure_no_send: got %0d sends while busy, required 0", sent_q.size());
    end
    busy_mode = 1;
    wait_sends("backpressure");
  endtask

  task automatic test_wrap_reset();
    int          guard;
    logic [31:0] e_nb;
    busy_mode = 1;
    load(32'hFFFF_FFFE);
    while (k < LOOP) tick();
    e_nb = cur_start + 32'(CORES * (k / LOOP));
    checks++;
    if (bus_if.nonce_base !== e_nb) begin
      errors++;
      $display("FAIL wrap_nonce_base: got %h, required %h", bus_if.nonce_base, e_nb);
    end
    while (k / LOOP < RO - 1) sample('0);
    busy_min = 8;
    busy_max = 8;
    sample(2'b11);
    guard = 0;
    while (sent_q.size() == 0 && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (sent_q.size() != 1 || sent_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL wrap_first_send: got %0d sends, first %h, required 1 send of %h",
               sent_q.size(), (sent_q.size() > 0) ? sent_q[0] : 32'h0, exp_q[0]);
    end
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset_outputs");
    repeat (2) @(negedge hash_clk);
    reset_n = 1'b1;
    k = 0;
    clear_model();
    busy_min = 1;
    busy_max = 4;
    repeat (20) tick();
    checks++;
    if (sent_q.size() != 0 || bus_if.hit_count !== 16'd0) begin
      errors++;
      $display("FAIL fifo_empty_after_reset: got %0d sends hits=%0d, required 0 sends hits=0",
               sent_q.size(), bus_if.hit_count);
    end
  endtask

  initial begin : main
    test_reset();
    test_sequencer();
    test_flush();
    test_golden();
    test_simultaneous();
    test_random();
    test_timeout();
    test_backpressure();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
